icache_controller: RTL and testbench



---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_tag_array.sv | 44 ++++
 rtl/icache_controller.sv | 164 ++++++++++++++++
 tb/tb_icache_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, default geometry and width helpers for the instruction cache.
package icache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Word-addressed memory: 30 address bits remain after dropping the byte offset.
  function automatic int tag_w(input int line_words, input int num_lines);
    return 30 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tag storage with a combinational hit compare,
// a synchronous tag/valid write port and a bulk-invalidate input.
module icache_tag_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             inv_all
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr [NUM_LINES];

  assign hit = valid[rd_idx] && (tag_arr[rd_idx] == rd_tag);

  // Valid bits: bulk invalidate overrides any single-line update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (inv_all) begin
      valid <= '0;
    end else begin
      if (inv_en)             valid[inv_idx] <= 1'b0;
      if (wr_en && wr_valid)  valid[wr_idx]  <= 1'b1;
    end
  end

  // Tag storage is not reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (wr_en) tag_arr[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller with line refill FSM and flush.
// Optional: define ICACHE_STATS_EN to add hit_count/miss_count outputs.
//
// state  | meaning
// IDLE   | serve hits combinationally; a miss starts a refill
// REFILL | read LINE_WORDS words in ascending order over req/ack
// DONE   | commit tag, set valid unless a flush arrived, return to IDLE
module icache_controller
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(LINE_WORDS, NUM_LINES);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       unused_byte_sel;

  assign offset          = cpu_addr[OFF_W+1:2];
  assign idx             = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign tag             = cpu_addr[31:IDX_W+OFF_W+2];
  assign unused_byte_sel = cpu_addr[1:0];

  state_t           state, next_state;
  logic [OFF_W-1:0] word_cnt;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic             flush_pend;
  logic             hit;
  logic             start_miss, tag_wr, set_valid, inv_all;
  logic [31:0]      data_arr [NUM_LINES*LINE_WORDS];

  icache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_tag   (tag),
    .hit      (hit),
    .inv_en   (start_miss),
    .inv_idx  (idx),
    .wr_en    (tag_wr),
    .wr_idx   (miss_idx),
    .wr_tag   (miss_tag),
    .wr_valid (set_valid),
    .inv_all  (inv_all)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and outputs; everything is forced quiet while rst is high.
  always_comb begin
    next_state = state;
    cpu_instr  = data_arr[{idx, offset}];
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    start_miss = 1'b0;
    tag_wr     = 1'b0;
    set_valid  = 1'b0;
    inv_all    = 1'b0;
    if (rst) begin
      cpu_instr = '0;
    end else begin
      case (state)
        IDLE: begin
          inv_all = flush;
          if (cpu_req && !hit) begin
            cpu_stall  = 1'b1;
            start_miss = 1'b1;
            next_state = REFILL;
          end
        end
        REFILL: begin
          mem_req   = 1'b1;
          mem_addr  = {miss_tag, miss_idx, word_cnt, 2'b00};
          cpu_stall = 1'b1;
          if (mem_ack && word_cnt == LAST_WORD) next_state = DONE;
        end
        DONE: begin
          cpu_stall  = 1'b1;
          tag_wr     = 1'b1;
          set_valid  = !(flush || flush_pend);
          inv_all    = flush || flush_pend;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Word counter and flush-pending flag for the refill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (start_miss)                     word_cnt <= '0;
      else if (state == REFILL && mem_ack) word_cnt <= word_cnt + 1'b1;
      if (state == REFILL && flush) flush_pend <= 1'b1;
      else if (state == DONE)       flush_pend <= 1'b0;
    end
  end

  // Miss address capture; only meaningful while a refill is in flight.
  always_ff @(posedge clk) begin
    if (start_miss) begin
      miss_tag <= tag;
      miss_idx <= idx;
    end
  end

  // Refill data write into the line being filled.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL && mem_ack) data_arr[{miss_idx, word_cnt}] <= mem_rdata;
  end

`ifdef ICACHE_STATS_EN
  logic hit_cycle;
  assign hit_cycle = (state == IDLE) && cpu_req && hit;

  // Hit/miss statistics; wrap naturally, unaffected by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_cycle)  hit_count  <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: memory model returns rdata = address,
// expected refill addresses and instructions are queued and compared on output.
module tb_icache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int mem_delay = 0;
  int wait_cnt  = 0;
  logic [31:0] addr_q [$];
  logic [31:0] instr_q [$];

  icache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model plus refill-address scoreboard; mem_addr must match the queue head every REFILL cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (addr_q.size() == 0) begin
        check("mem_unexpected_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
      end else begin
        check("mem_addr", mem_addr, addr_q[0]);
        if (wait_cnt == mem_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr;
          wait_cnt  = 0;
          void'(addr_q.pop_front());
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // One fetch: hold the request until the stall clears; nfills refills expected.
  task automatic access(input logic [31:0] a, input int delay, input int nfills, input int flush_at);
    int stalls;
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    mem_delay = delay;
    for (int f = 0; f < nfills; f++)
      for (int w = 0; w < 4; w++) addr_q.push_back(base + 32'(4 * w));
    instr_q.push_back(a & 32'hFFFF_FFFC);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    flush    = (flush_at == 0);
    #1;
    stalls = 0;
    while (cpu_stall && stalls < 300) begin
      stalls++;
      @(negedge clk);
      flush = (stalls == flush_at);
      #1;
    end
    flush = 1'b0;
    check("stall_bound", {31'd0, stalls < 300}, 32'd1);
    check("stall_cycles", 32'(stalls), 32'(nfills * (2 + 4 * (delay + 1))));
    check("instr", cpu_instr, instr_q.pop_front());
    check("hit_mem_req", {31'd0, mem_req}, 32'd0);
    check("refill_words_left", 32'(addr_q.size()), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h104; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr", cpu_instr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;

    // Cold miss: delivered 6 cycles after the miss cycle.
    access(32'h104, 0, 1, -1);
    // Hit in the line just filled.
    access(32'h10C, 0, 0, -1);
    // Conflict eviction on index 0, then the original line misses again.
    access(32'h200, 0, 1, -1);
    access(32'h100, 0, 1, -1);
`ifdef ICACHE_STATS_EN
    check("miss_count", miss_count, 32'd3);
    check("hit_count", hit_count, 32'd4);
`endif
    // Slow memory: three wait cycles per word.
    access(32'h508, 3, 1, -1);
    // Flush on the 2nd REFILL cycle: line stays invalid, so the held fetch refills again.
    access(32'h300, 0, 2, 2);
    access(32'h304, 0, 0, -1);
    // Flush in IDLE invalidates everything.
    pulse_flush();
    access(32'h300, 0, 1, -1);
    // Flush in the same cycle as a miss: other lines cleared, the miss still fills.
    access(32'h314, 0, 1, -1);
    access(32'h600, 0, 1, 0);
    access(32'h604, 0, 0, -1);
    access(32'h318, 0, 1, -1);

    // Reset after two acks of a refill.
    addr_q.push_back(32'h400);
    addr_q.push_back(32'h404);
    mem_delay = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h400;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stall", {31'd0, cpu_stall}, 32'd0);
    check("midrst_instr", cpu_instr, 32'd0);
    check("midrst_partial", 32'(addr_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk); #1;
    check("postrst_mem_req", {31'd0, mem_req}, 32'd0);
    access(32'h400, 0, 1, -1);
    access(32'h40C, 0, 0, -1);

    repeat (3) @(negedge clk);
    check("final_queue", 32'(addr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
